fetch_unit: RTL and testbench

Instruction fetch front end between `program_counter` and instruction memory. It consumes the current PC, issues in-order requests to instruction memory over a valid/ready interface, and buffers returned instruction words with their PCs. It presents them to decode over a valid/ready handshake. On a taken branch it discards every queued and in-flight fetch so that decode only ever sees the redirected stream.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV32 front end.
//   XLEN / ILEN : architectural address and instruction widths
//   NOP_INSN    : addi x0,x0,0, which decode substitutes when inst_valid is low
//   RESET_PC    : fetch address after reset, shared with program_counter
//   cnt_width() : bits needed to hold an occupancy count of 0..depth
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write push_data (accepted when not full, or when full and popping)
//   pop        drop the head entry (ignored when empty)
//   clear      synchronous flush of all entries
//   head       current head entry, valid while !empty
//   count      occupancy 0..DEPTH
//   full/empty occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  import riscv_pkg::*;

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == CW'(DEPTH));
    do_pop  = pop && !empty;
    // A full FIFO may still take a write when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
    count   = cnt;
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end between program_counter and imem.
// Issues in-order requests for pc, tracks in-flight PCs in a tag FIFO, queues
// returned {pc, word} pairs for decode, and discards everything older than a
// taken branch (flush) by counting responses still owed in drop_cnt.
// Parameters: DEPTH (total fetch credits, power of two, >= 2), XLEN.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc, pc_stall                  fetch address in; hold request out
//   flush                         redirect, same cycle as the PC's branch_en
//   imem_req_valid/addr/ready     request channel to instruction memory
//   imem_rsp_valid/data           in-order, non-backpressurable responses
//   inst_valid/data/pc/ready      instruction channel to decode
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// decode in its own cycle when nothing older is queued or being dropped.
module fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_stall,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  import riscv_pkg::*;

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned UW = CW + 2;

  logic [CW-1:0]     tag_count;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     flush_drop;
  logic [UW-1:0]     used;
  logic [UW-1:0]     flush_sum;
  logic              tag_full;
  logic              tag_empty;
  logic              q_full;
  logic              q_empty;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] q_head;
  logic              req_fire;
  logic              rsp_live;
  logic              rsp_drop;
  logic              rsp_take;
  logic              bypass_hit;
  logic              q_push;
  logic              q_pop;

  always_comb begin
    // Every credit is either in flight, owed as a drop, or sitting in the
    // queue, so a response always finds room without back-pressure.
    used = UW'(tag_count) + UW'(drop_cnt) + UW'(q_count);

    imem_req_valid = !rst && !flush && (used < UW'(DEPTH));
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    pc_stall       = rst || (!flush && !req_fire);

    // A response during flush belongs to the discarded stream.
    rsp_live = imem_rsp_valid && !rst && !flush;
    rsp_drop = rsp_live && (drop_cnt != '0);
    rsp_take = rsp_live && (drop_cnt == '0) && !tag_empty;

`ifdef FETCH_BYPASS_EN
    bypass_hit = rsp_take && q_empty;
`else
    bypass_hit = 1'b0;
`endif

    inst_valid = !rst && !flush && (!q_empty || bypass_hit);
    inst_pc    = bypass_hit ? tag_head      : q_head[2*XLEN-1 -: XLEN];
    inst_data  = bypass_hit ? imem_rsp_data : q_head[XLEN-1:0];

    q_pop  = inst_valid && inst_ready && !q_empty;
    q_push = rsp_take && !(bypass_hit && inst_ready);

    // Everything in flight at the flush becomes a drop; a response landing
    // in the flush cycle itself settles one of those debts immediately.
    flush_sum = UW'(drop_cnt) + UW'(tag_count);
    if (imem_rsp_valid && (flush_sum != '0)) begin
      flush_sum = flush_sum - 1'b1;
    end
    flush_drop = CW'(flush_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= flush_drop;
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_take),
    .clear     (flush),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (q_pop),
    .clear     (flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid && (drop_cnt == '0) && tag_empty) begin
      $error("fetch_unit: response with no outstanding request");
    end
    if (!rst && req_fire && tag_full) begin
      $error("fetch_unit: request issued with tag FIFO full");
    end
    if (!rst && q_push && q_full && !q_pop) begin
      $error("fetch_unit: instruction queue overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_stall;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(
    .DEPTH (2),
    .XLEN  (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_stall       (pc_stall),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  mreq_t mq[$];
  exp_t  sb_q[$];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;

  // Controls staged by the test sequence, applied at the next falling edge.
  logic        c_rst = 1'b1;
  logic        c_fl  = 1'b0;
  logic        c_rr  = 1'b1;
  logic        c_ir  = 1'b1;
  logic [31:0] c_tgt = '0;
  logic [31:0] pc_nxt = '0;

  logic        s_fire;
  logic        s_stall;
  logic        s_req_valid;
  logic        s_inst_valid;
  logic [31:0] s_inst_data;
  logic [31:0] s_inst_pc;
  logic [31:0] s_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_inst(input logic [31:0] p, input logic [31:0] d);
    exp_t e;
    e.pc   = p;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // One clock cycle: drive inputs (with the memory model and the program
  // counter model) at the falling edge, then sample the combinational outputs.
  task automatic step();
    mreq_t m;
    @(negedge clk);
    cyc++;
    rst            = c_rst;
    flush          = c_fl;
    imem_req_ready = c_rr;
    inst_ready     = c_ir;
    pc             = pc_nxt;
    if (c_rst) mq.delete();
    if (mq.size() > 0 && mq[0].due == cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~m.addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_fire       = imem_req_valid && imem_req_ready;
    s_stall      = pc_stall;
    s_req_valid  = imem_req_valid;
    s_inst_valid = inst_valid;
    s_inst_data  = inst_data;
    s_inst_pc    = inst_pc;
    s_addr       = imem_req_addr;
    if (s_fire) begin
      m.addr = imem_req_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
    end
    if (c_rst)      pc_nxt = 32'h0;
    else if (c_fl)  pc_nxt = c_tgt;
    else if (!s_stall) pc_nxt = pc + 32'd4;
    #2;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    c_rr  = 1'b0;
    c_fl  = 1'b1;
    c_tgt = tgt;
    step();
    c_fl  = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k;
    k = 0;
    c_rr = 1'b0;
    c_ir = 1'b1;
    while ((sb_q.size() != 0 || mq.size() != 0) && k < 40) begin
      step();
      k++;
    end
    step();
    check({name, "_drain_left"}, sb_q.size() + mq.size(), 32'd0);
  endtask

  task automatic fire_once(input string name, input logic [31:0] addr, output int unsigned waited);
    int unsigned k;
    k = 0;
    c_rr = 1'b1;
    step();
    while (!s_fire && k < 20) begin
      k++;
      step();
    end
    c_rr = 1'b0;
    waited = k;
    check({name, "_fired"}, s_fire, 1'b1);
    check({name, "_addr"}, s_addr, addr);
  endtask

  // Monitor: every decode handshake pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL inst_unexpected: got pc=%h data=%h, required no instruction", inst_pc, inst_data);
      end else begin
        e = sb_q.pop_front();
        if (inst_pc !== e.pc || inst_data !== e.data) begin
          n_bad++;
          $display("FAIL inst_stream: got pc=%h data=%h, required pc=%h data=%h",
                   inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned got;
    int unsigned w;

    rst = 1'b1; flush = 1'b0; pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

    // Reset values; rst beats a simultaneous flush.
    step();
    step();
    check("rst_req_valid", s_req_valid, 1'b0);
    check("rst_pc_stall", s_stall, 1'b1);
    check("rst_inst_valid", s_inst_valid, 1'b0);
    c_fl = 1'b1;
    step();
    check("rst_flush_stall", s_stall, 1'b1);
    check("rst_flush_req_valid", s_req_valid, 1'b0);
    c_fl = 1'b0;
    check("rst_drop_cnt", 32'(dut.drop_cnt), 32'd0);

    // Latency 1 stream of 0x0, 0x4, 0x8.
    expect_inst(32'h0000_0000, 32'hFFFF_FFFF);
    expect_inst(32'h0000_0004, 32'hFFFF_FFFB);
    expect_inst(32'h0000_0008, 32'hFFFF_FFF7);
    c_rst = 1'b0;
    c_rr  = 1'b1;
    got   = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check("t1_first_stall", s_stall, 1'b0);
      if (s_fire) begin
        check("t1_req_addr", s_addr, got * 4);
        got++;
        if (got == 3) break;
      end
    end
    c_rr = 1'b0;
    check("t1_fire_count", got, 32'd3);
    drain("t1");

    // Decode stalled: two credits used, then fetch holds at 0x14.
    c_ir = 1'b0;
    c_rr = 1'b1;
    step();
    check("t2_fire0", {s_fire, s_addr}, {1'b1, 32'h0000_000C});
    step();
    check("t2_fire1", {s_fire, s_addr}, {1'b1, 32'h0000_0010});
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_req_valid", s_req_valid, 1'b0);
      check("t2_hold_stall", s_stall, 1'b1);
      check("t2_hold_addr", s_addr, 32'h0000_0014);
    end
    expect_inst(32'h0000_000C, 32'hFFFF_FFF3);
    expect_inst(32'h0000_0010, 32'hFFFF_FFEF);
    expect_inst(32'h0000_0014, 32'hFFFF_FFEB);
    c_ir = 1'b1;
    fire_once("t2_resume", 32'h0000_0014, w);
    drain("t2");

    // Memory not ready for 3 cycles at PC 0x10.
    redirect(32'h0000_0010);
    check("t3_flush_stall", s_stall, 1'b0);
    check("t3_flush_req_valid", s_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall", s_stall, 1'b1);
      check("t3_req_valid", s_req_valid, 1'b1);
      check("t3_addr", s_addr, 32'h0000_0010);
    end
    expect_inst(32'h0000_0010, 32'hFFFF_FFEF);
    fire_once("t3_accept", 32'h0000_0010, w);
    check("t3_accept_wait", w, 32'd0);
    drain("t3");

    // Latency 3, two requests in flight, flush to 0x100.
    redirect(32'h0000_0020);
    lat  = 3;
    c_rr = 1'b1;
    step();
    check("t4_fire0", {s_fire, s_addr}, {1'b1, 32'h0000_0020});
    step();
    check("t4_fire1", {s_fire, s_addr}, {1'b1, 32'h0000_0024});
    redirect(32'h0000_0100);
    check("t4_flush_inst_valid", s_inst_valid, 1'b0);
    check("t4_flush_stall", s_stall, 1'b0);
    @(posedge clk);
    #1;
    check("t4_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    expect_inst(32'h0000_0100, 32'hFFFF_FEFF);
    fire_once("t4_target", 32'h0000_0100, w);
    check("t4_target_wait", w, 32'd1);
    drain("t4");
    check("t4_drop_cnt_end", 32'(dut.drop_cnt), 32'd0);

    // Flush in the same cycle as the response for 0x40.
    redirect(32'h0000_0040);
    lat  = 2;
    c_rr = 1'b1;
    step();
    check("t5_fire0", {s_fire, s_addr}, {1'b1, 32'h0000_0040});
    step();
    check("t5_fire1", {s_fire, s_addr}, {1'b1, 32'h0000_0044});
    redirect(32'h0000_0200);
    check("t5_rsp_in_flush", imem_rsp_valid, 1'b1);
    check("t5_flush_inst_valid", s_inst_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t5_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    step();
    @(posedge clk);
    #1;
    check("t5_drop_cnt_after", 32'(dut.drop_cnt), 32'd0);
    expect_inst(32'h0000_0200, 32'hFFFF_FDFF);
    fire_once("t5_target", 32'h0000_0200, w);
    drain("t5");

    // Response-to-decode latency with an empty queue.
    redirect(32'h2152_4110);
    lat = 1;
    expect_inst(32'h2152_4110, 32'hDEAD_BEEF);
    fire_once("t6_req", 32'h2152_4110, w);
    step();
    check("t6_rsp_valid", imem_rsp_valid, 1'b1);
    check("t6_inst_valid_n", s_inst_valid, BYP);
    check("t6_inst_data_n", BYP ? s_inst_data : 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    check("t6_inst_valid_n1", s_inst_valid, !BYP);
    check("t6_inst_data_n1", BYP ? 32'hDEAD_BEEF : s_inst_data, 32'hDEAD_BEEF);
    drain("t6");

    // Reset in the middle of traffic clears all state.
    c_ir = 1'b0;
    c_rr = 1'b1;
    step();
    step();
    c_rst = 1'b1;
    step();
    check("t7_rst_inst_valid", s_inst_valid, 1'b0);
    check("t7_rst_req_valid", s_req_valid, 1'b0);
    check("t7_rst_stall", s_stall, 1'b1);
    @(posedge clk);
    #1;
    check("t7_state_counts", {32'(dut.drop_cnt), 32'(dut.tag_count), 32'(dut.q_count)}, '0);
    c_rst = 1'b0;
    c_rr  = 1'b0;
    c_ir  = 1'b1;
    step();
    check("t7_after_inst_valid", s_inst_valid, 1'b0);
    check("t7_after_addr", s_addr, 32'h0000_0000);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
